// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between port 0 (fetch/branch) and port 1 (execute); optional ALU_ARB_LOCK_EN adds lock0/lock1.
// Latency: accept edge T, result captured at T+1, rspN_valid seen at edge T+2; minimum issue interval 3 cycles.
// Backpressure: reqN_ready only in IDLE; the response is held stable until rspN_ready, and no new request is taken meanwhile.
module alu_arbiter #(
    parameter int REG_WIDTH = 8,
    parameter int OP_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [OP_WIDTH-1:0]  req0_op,
    input  logic [REG_WIDTH-1:0] req0_a,
    input  logic [REG_WIDTH-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [OP_WIDTH-1:0]  req1_op,
    input  logic [REG_WIDTH-1:0] req1_a,
    input  logic [REG_WIDTH-1:0] req1_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic                 lock0,
    input  logic                 lock1,
`endif
    output logic [REG_WIDTH-1:0] alu_ra,
    output logic [REG_WIDTH-1:0] alu_rb,
    output logic [OP_WIDTH-1:0]  alu_op,
    input  logic [REG_WIDTH-1:0] alu_res,
    input  logic [REG_WIDTH-1:0] alu_car,
    input  logic                 alu_zero,
    input  logic                 alu_jump,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [REG_WIDTH-1:0] rsp_res,
    output logic [REG_WIDTH-1:0] rsp_car,
    output logic                 rsp_zero,
    output logic                 rsp_jump,
    output logic                 rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gid_q, gid_d;
    logic                  lock_q, lock_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic [REG_WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [REG_WIDTH-1:0]  res_q, res_d, car_q, car_d;
    logic                  zero_q, zero_d, jump_q, jump_d, err_q, err_d;
    logic                  hold, grant0, grant1, lock_in;

`ifdef ALU_ARB_LOCK_EN
    // Lock persists only while the locked port keeps its lock input high.
    assign hold    = lock_q && (last_grant_q ? lock1 : lock0);
    assign lock_in = grant1 ? lock1 : lock0;
`else
    assign hold    = 1'b0;
    assign lock_in = 1'b0;
`endif

    // rst_n gates ready so outputs are all zero while reset is asserted.
    assign grant0 = (state_q == IDLE) && rst_n && req0_valid &&
                    (hold ? (last_grant_q == 1'b0) : (!req1_valid || last_grant_q != 1'b0));
    assign grant1 = (state_q == IDLE) && rst_n && req1_valid &&
                    (hold ? (last_grant_q == 1'b1) : (!req0_valid || last_grant_q != 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            lock_q       <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            car_q        <= '0;
            zero_q       <= 1'b0;
            jump_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gid_q        <= gid_d;
            lock_q       <= lock_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            car_q        <= car_d;
            zero_q       <= zero_d;
            jump_q       <= jump_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gid_d        = gid_q;
        lock_d       = lock_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        car_d        = car_q;
        zero_d       = zero_q;
        jump_d       = jump_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d      = EXEC;
                    gid_d        = grant1;
                    last_grant_d = grant1;
                    lock_d       = lock_in;
                    op_d         = grant1 ? req1_op : req0_op;
                    a_d          = grant1 ? req1_a  : req0_a;
                    b_d          = grant1 ? req1_b  : req0_b;
                end
            end
            EXEC: begin
                state_d = RESP;
                if (op_q > OP_WIDTH'(10)) begin
                    res_d  = '0;
                    car_d  = '0;
                    zero_d = 1'b0;
                    jump_d = 1'b0;
                    err_d  = 1'b1;
                end else begin
                    res_d  = alu_res;
                    zero_d = alu_zero;
                    err_d  = 1'b0;
                    car_d  = (op_q inside {4, 5, 8, 9, 10}) ? alu_car : '0;
                    jump_d = (op_q == OP_WIDTH'(7)) ? alu_jump : 1'b0;
                end
            end
            RESP: begin
                if (gid_q ? rsp1_ready : rsp0_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        alu_ra     = (state_q != IDLE) ? a_q  : '0;
        alu_rb     = (state_q != IDLE) ? b_q  : '0;
        alu_op     = (state_q != IDLE) ? op_q : '0;
        rsp0_valid = (state_q == RESP) && !gid_q;
        rsp1_valid = (state_q == RESP) && gid_q;
        rsp_res    = res_q;
        rsp_car    = car_q;
        rsp_zero   = zero_q;
        rsp_jump   = jump_q;
        rsp_err    = err_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the bench plays the ALU with hand-chosen result values.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [7:0] alu_ra, alu_rb;
    logic [3:0] alu_op;
    logic [7:0] alu_res, alu_res_drv, alu_car;
    logic       alu_zero, alu_jump;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp_res, rsp_car;
    logic       rsp_zero, rsp_jump, rsp_err;
    logic       pass_mode;
`ifdef ALU_ARB_LOCK_EN
    logic       lock0, lock1;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Pass-through mode lets the result identify which operand set was executed.
    assign alu_res = pass_mode ? alu_ra : alu_res_drv;

    alu_arbiter #(.REG_WIDTH(8), .OP_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
`ifdef ALU_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op),
        .alu_res(alu_res), .alu_car(alu_car), .alu_zero(alu_zero), .alu_jump(alu_jump),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_res(rsp_res), .rsp_car(rsp_car), .rsp_zero(rsp_zero), .rsp_jump(rsp_jump), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where the response is first visible.
    task automatic issue(input int p, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        if (p == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            if ((p == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", ok, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("exec_ra", alu_ra, a);
        check("exec_rb", alu_rb, b);
        check("exec_op", alu_op, op);
        check("exec_no_rsp", rsp0_valid | rsp1_valid, 0);
        @(negedge clk);
        check("rsp_lat", (p == 0) ? rsp0_valid : rsp1_valid, 1);
        check("rsp_other", (p == 0) ? rsp1_valid : rsp0_valid, 0);
    endtask

    task automatic consume(input int p);
        if (p == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        check("rsp_drop", rsp0_valid | rsp1_valid, 0);
        check("idle_alu_ra", alu_ra, 0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic run_seq(input string tag, input int n, input logic [7:0] exp_seq, input int unlock_at);
        int got;
        got = 0;
        req0_op = 4'd0; req1_op = 4'd0;
        req0_a = 8'hA0; req1_a = 8'hB1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 60 && got < n; c++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                check({tag, "_grant"}, rsp1_valid, exp_seq[got]);
                check({tag, "_res"}, rsp_res, exp_seq[got] ? 8'hB1 : 8'hA0);
                check({tag, "_one"}, rsp0_valid & rsp1_valid, 0);
                got++;
`ifdef ALU_ARB_LOCK_EN
                if (got == unlock_at) lock0 = 1'b0;
`endif
                if (got == n) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        check({tag, "_count"}, got, n);
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        if (unlock_at < 0) check({tag, "_unused"}, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; pass_mode = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        alu_res_drv = '0; alu_car = '0; alu_zero = 1'b0; alu_jump = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("rst_alu", {alu_ra, alu_rb, alu_op}, 0);
        check("rst_rsp", {rsp_res, rsp_car, rsp_zero, rsp_jump, rsp_err}, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // op 4: carry passes through, stale jump masked.
        alu_res_drv = 8'h10; alu_car = 8'h01; alu_zero = 1'b0; alu_jump = 1'b1;
        issue(0, 4'd4, 8'hF0, 8'h20);
        check("t1_res", rsp_res, 8'h10);
        check("t1_car", rsp_car, 8'h01);
        check("t1_zero", rsp_zero, 0);
        check("t1_jump", rsp_jump, 0);
        check("t1_err", rsp_err, 0);
        consume(0);

        // Both ports always valid: alternate starting at port 0.
        do_reset();
        pass_mode = 1'b1;
        run_seq("rr", 6, 8'b0010_1010, 0);
        pass_mode = 1'b0;

        // op 7 passes jump; op 2 masks jump and carry.
        alu_res_drv = 8'h00; alu_zero = 1'b1; alu_car = 8'h01; alu_jump = 1'b1;
        issue(1, 4'd7, 8'h33, 8'h33);
        check("t3_jump", rsp_jump, 1);
        check("t3_car", rsp_car, 0);
        check("t3_zero", rsp_zero, 1);
        consume(1);
        alu_res_drv = 8'h66; alu_zero = 1'b0;
        issue(1, 4'd2, 8'h33, 8'h33);
        check("t3b_jump", rsp_jump, 0);
        check("t3b_car", rsp_car, 0);
        check("t3b_res", rsp_res, 8'h66);
        consume(1);

        // Illegal opcode, response stalled for five cycles.
        alu_res_drv = 8'h55; alu_car = 8'h01; alu_zero = 1'b1; alu_jump = 1'b1;
        issue(0, 4'd12, 8'h01, 8'h02);
        check("t4_res", rsp_res, 0);
        check("t4_car", rsp_car, 0);
        check("t4_zero", rsp_zero, 0);
        check("t4_jump", rsp_jump, 0);
        check("t4_err", rsp_err, 1);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp1_ready = 1'b1; alu_res_drv = 8'hAA;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_valid", {rsp0_valid, rsp1_valid}, 2'b10);
            check("t4_hold_data", {rsp_res, rsp_err}, {8'h00, 1'b1});
            check("t4_hold_ready", {req0_ready, req1_ready}, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp1_ready = 1'b0;
        consume(0);

        alu_res_drv = 8'h21; alu_car = 8'h01; alu_zero = 1'b0; alu_jump = 1'b0;
        issue(0, 4'd5, 8'h10, 8'h11);
        check("t4b_err", rsp_err, 0);
        check("t4b_res", rsp_res, 8'h21);
        check("t4b_car", rsp_car, 8'h01);
        consume(0);

        // Reset while in EXEC after a port-0 grant.
        req0_op = 4'd4; req0_a = 8'hF0; req0_b = 8'h20; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        check("t5_exec_op", alu_op, 4'd4);
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t5_rst_alu", {alu_ra, alu_rb, alu_op}, 0);
        check("t5_rst_rsp", {rsp0_valid, rsp1_valid, rsp_res, rsp_car, rsp_err}, 0);
        check("t5_rst_ready", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t5_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t5_tie", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

`ifdef ALU_ARB_LOCK_EN
        do_reset();
        pass_mode = 1'b1;
        lock0 = 1'b1;
        run_seq("lock", 4, 8'b0000_1000, 3);
        pass_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
